// File: rtl/miter_pkg.sv
// Shared definitions for the LUT-techmap equivalence miter.
// Latency: n/a (constants and a pure combinational gold function).
// Backpressure: n/a.
//
// Contents: result field layout, INIT truth tables for every lut4 flavour
// used by the gate path, and the behavioural reference function f_gold.
// LUT truth tables are indexed by {I3,I2,I1,I0}; inputs a function does
// not use are don't-care, so the pattern is replicated across them.
package miter_pkg;

  localparam int RES_W    = 8;
  localparam int NIB_W    = 4;
  localparam int SUM_W    = 5;
  localparam int SUM_LSB  = 0;
  localparam int PAR_BIT  = 5;
  localparam int GT_BIT   = 6;
  localparam int ZERO_BIT = 7;

  // O = I0 ^ I1 ^ I2 (I3 ignored)
  localparam logic [15:0] LUT_XOR3     = 16'h9696;
  // O = majority(I0, I1, I2) (I3 ignored) -- ripple carry
  localparam logic [15:0] LUT_MAJ3     = 16'hE8E8;
  // O = ~(I0 | I1 | I2 | I3)
  localparam logic [15:0] LUT_NOR4     = 16'h0001;
  // O = I0 & I1 (I2, I3 ignored)
  localparam logic [15:0] LUT_AND2     = 16'h8888;
  // O = I0 ^ I1 ^ I2 ^ I3
  localparam logic [15:0] LUT_XOR4     = 16'h6996;
  // Comparator, least-significant stage: O = I0 & ~I1 (a_i > b_i)
  localparam logic [15:0] LUT_GT_FIRST = 16'h2222;
  // Comparator cascade stage, I0 = a_i, I1 = b_i, I2 = gt from lower bits:
  // O = (a_i & ~b_i) | (~(a_i ^ b_i) & gt_in). Higher bit decides, ties defer.
  localparam logic [15:0] LUT_GT_CASC  = 16'hB2B2;

  // Behavioural reference of the function under test.
  function automatic logic [RES_W-1:0] f_gold(input logic [RES_W-1:0] a);
    logic [RES_W-1:0] y;
    logic [NIB_W-1:0] lo;
    logic [NIB_W-1:0] hi;
    lo = a[NIB_W-1:0];
    hi = a[RES_W-1:NIB_W];
    y = '0;
    y[SUM_LSB +: SUM_W] = {1'b0, lo} + {1'b0, hi};
    y[PAR_BIT]          = ^a;
    y[GT_BIT]           = (lo > hi);
    y[ZERO_BIT]         = (a == 8'h00);
    return y;
  endfunction

endpackage

// File: rtl/dut_miter_if.sv
// Operand/result bundle between the sweep driver and the miter.
// Latency: n/a (wires only).
// Backpressure: none; a new operand is accepted every cycle.
//
// Signals: in_A (operand, driver -> miter), trigger (mismatch pulse),
// y_ref (registered gold result).
interface dut_miter_if;
  import miter_pkg::*;

  logic [RES_W-1:0] in_A;
  logic             trigger;
  logic [RES_W-1:0] y_ref;

  modport master (
    output in_A,
    input  trigger,
    input  y_ref
  );

  modport slave (
    input  in_A,
    output trigger,
    output y_ref
  );

endinterface

// File: rtl/lut4.sv
// Generic 4-input lookup-table cell used to build the gate-level path.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports: I0..I3 select inputs (I3 most significant), O = INIT[{I3,I2,I1,I0}].
module lut4 #(
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic I0,
  input  logic I1,
  input  logic I2,
  input  logic I3,
  output logic O
);

  assign O = INIT[{I3, I2, I1, I0}];

endmodule

// File: rtl/dut_miter.sv
// Equivalence miter: behavioural gold vs lut4 netlist of the same 8-bit function.
// Latency: 1 cycle from in_A to trigger / y_ref.
// Backpressure: none; accepts a new operand every cycle, trigger is a per-cycle pulse.
//
// Ports: clk, rst_n (async active-low), bus.slave { in_A in, trigger out, y_ref out }.
// Parameter INJECT_FAULT = 1 inverts the gate-path parity bit so the miter must fire.
module dut_miter
  import miter_pkg::*;
#(
  parameter bit INJECT_FAULT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  dut_miter_if.slave  bus
);

  // Fault injection is done inside the netlist itself by complementing the
  // final parity LUT's truth table, so no behavioural logic enters the gate path.
  localparam logic [15:0] PAR_INIT = INJECT_FAULT ? ~LUT_XOR3 : LUT_XOR3;

  logic [NIB_W-1:0] w_a;
  logic [NIB_W-1:0] w_b;
  logic [RES_W-1:0] w_y_gold;
  logic [RES_W-1:0] w_y_gate;
  logic             w_mismatch;

  logic [NIB_W-1:0] w_sum;
  logic [NIB_W:0]   w_carry;
  logic [NIB_W:0]   w_gt;
  logic             w_par_lo;
  logic             w_par_hi;
  logic             w_par;
  logic             w_nz_lo;
  logic             w_nz_hi;
  logic             w_zero;

  logic             r_trigger;
  logic [RES_W-1:0] r_y_ref;

  assign w_a = bus.in_A[NIB_W-1:0];
  assign w_b = bus.in_A[RES_W-1:NIB_W];

  // ---------------------------------------------------------------- gold
  assign w_y_gold = f_gold(bus.in_A);

  // ---------------------------------------------------------------- gate
  // Ripple adder: carry-in of the LSB is tied low; the final carry is sum bit 4.
  assign w_carry[0] = 1'b0;

  // Magnitude compare a > b, cascaded from the LSB upward so the most
  // significant differing bit is the last one to override the running result.
  assign w_gt[0] = 1'b0;

  generate
    for (genvar i = 0; i < NIB_W; i++) begin : g_bit
      lut4 #(.INIT(LUT_XOR3)) u_sum (
        .I0 (w_a[i]),
        .I1 (w_b[i]),
        .I2 (w_carry[i]),
        .I3 (1'b0),
        .O  (w_sum[i])
      );

      lut4 #(.INIT(LUT_MAJ3)) u_cy (
        .I0 (w_a[i]),
        .I1 (w_b[i]),
        .I2 (w_carry[i]),
        .I3 (1'b0),
        .O  (w_carry[i+1])
      );

      if (i == 0) begin : g_gt_first
        lut4 #(.INIT(LUT_GT_FIRST)) u_gt (
          .I0 (w_a[i]),
          .I1 (w_b[i]),
          .I2 (w_gt[i]),
          .I3 (1'b0),
          .O  (w_gt[i+1])
        );
      end else begin : g_gt_casc
        lut4 #(.INIT(LUT_GT_CASC)) u_gt (
          .I0 (w_a[i]),
          .I1 (w_b[i]),
          .I2 (w_gt[i]),
          .I3 (1'b0),
          .O  (w_gt[i+1])
        );
      end
    end
  endgenerate

  // Parity: one XOR4 per nibble, combined by a third LUT.
  lut4 #(.INIT(LUT_XOR4)) u_par_lo (
    .I0 (w_a[0]), .I1 (w_a[1]), .I2 (w_a[2]), .I3 (w_a[3]),
    .O  (w_par_lo)
  );

  lut4 #(.INIT(LUT_XOR4)) u_par_hi (
    .I0 (w_b[0]), .I1 (w_b[1]), .I2 (w_b[2]), .I3 (w_b[3]),
    .O  (w_par_hi)
  );

  lut4 #(.INIT(PAR_INIT)) u_par (
    .I0 (w_par_lo), .I1 (w_par_hi), .I2 (1'b0), .I3 (1'b0),
    .O  (w_par)
  );

  // Zero detect: each nibble NOR'd, then AND of the two "nibble is zero" flags.
  lut4 #(.INIT(LUT_NOR4)) u_nz_lo (
    .I0 (w_a[0]), .I1 (w_a[1]), .I2 (w_a[2]), .I3 (w_a[3]),
    .O  (w_nz_lo)
  );

  lut4 #(.INIT(LUT_NOR4)) u_nz_hi (
    .I0 (w_b[0]), .I1 (w_b[1]), .I2 (w_b[2]), .I3 (w_b[3]),
    .O  (w_nz_hi)
  );

  lut4 #(.INIT(LUT_AND2)) u_zero (
    .I0 (w_nz_lo), .I1 (w_nz_hi), .I2 (1'b0), .I3 (1'b0),
    .O  (w_zero)
  );

  always_comb begin
    w_y_gate                      = '0;
    w_y_gate[SUM_LSB +: SUM_W]    = {w_carry[NIB_W], w_sum};
    w_y_gate[PAR_BIT]             = w_par;
    w_y_gate[GT_BIT]              = w_gt[NIB_W];
    w_y_gate[ZERO_BIT]            = w_zero;
  end

  // ------------------------------------------------------------- compare
  assign w_mismatch = (w_y_gold != w_y_gate);

  // Outputs are plain per-cycle samples: no history, so release from reset
  // mid-sweep reports the operand present at the first live edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trigger <= 1'b0;
      r_y_ref   <= '0;
    end else begin
      r_trigger <= w_mismatch;
      r_y_ref   <= w_y_gold;
    end
  end

  assign bus.trigger = r_trigger;
  assign bus.y_ref   = r_y_ref;

endmodule

// File: tb/tb_dut_miter.sv
// Bench for dut_miter: a clean instance and a fault-injected instance share
// the same operand stream; expected results are queued at drive time and a
// monitor pops one entry per captured edge.
module tb_dut_miter;

  logic clk;
  logic rst_n;

  dut_miter_if bus0 ();
  dut_miter_if bus1 ();

  dut_miter #(.INJECT_FAULT(1'b0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  dut_miter #(.INJECT_FAULT(1'b1)) u_dut_f (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
  endtask

  // Reference: the function written directly from its arithmetic definition.
  function automatic logic [7:0] model(input int a);
    int lo;
    int hi;
    int r;
    lo = a % 16;
    hi = a / 16;
    r  = lo + hi;
    if (($countones(a) % 2) == 1) r += 32;
    if (lo > hi)                  r += 64;
    if (a == 0)                   r += 128;
    return 8'(r);
  endfunction

  // Drive both instances and record the expectation for the next edge.
  task automatic apply(input logic [7:0] a, input logic [7:0] e);
    bus0.in_A = a;
    bus1.in_A = a;
    exp_q.push_back(e);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_yref"},    bus0.y_ref,           8'h00);
    chk({tag, "_trig"},    {7'd0, bus0.trigger}, 8'h00);
    chk({tag, "_yref_f"},  bus1.y_ref,           8'h00);
    chk({tag, "_trig_f"},  {7'd0, bus1.trigger}, 8'h00);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 10) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("drain_empty", 8'(exp_q.size()), 8'h00);
  endtask

  // Monitor: every live edge that captured a queued operand is checked.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("yref",   bus0.y_ref,           e);
        chk("trig",   {7'd0, bus0.trigger}, 8'h00);
        chk("yref_f", bus1.y_ref,           e);
        chk("trig_f", {7'd0, bus1.trigger}, 8'h01);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    bus0.in_A = 8'h00;
    bus1.in_A = 8'h00;

    // Reset held while the operand toggles.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus0.in_A = 8'($urandom_range(0, 255));
      bus1.in_A = bus0.in_A;
      @(posedge clk);
      #1;
      check_cleared("rst_hold");
    end

    // Point values.
    @(negedge clk); rst_n = 1'b1; apply(8'h00, 8'h80);
    @(negedge clk); apply(8'hFF, 8'h1E);
    @(negedge clk); apply(8'h0F, 8'h4F);
    @(negedge clk); apply(8'h01, 8'h61);

    // Random operands.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 255));
      @(negedge clk);
      apply(8'(r), model(r));
    end

    // Exhaustive sweep.
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      apply(8'(a), model(a));
    end
    drain();

    // Asynchronous assertion mid-cycle clears outputs before the next edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_cleared("rst_async");

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus0.in_A = 8'($urandom_range(0, 255));
      bus1.in_A = bus0.in_A;
      @(posedge clk);
      #1;
      check_cleared("rst_hold2");
    end

    // Release mid-sweep at 7F, continue through the FF -> 00 wrap.
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h7F, 8'h76);
    for (int a = 8'h80; a < 8'hFF; a++) begin
      @(negedge clk);
      apply(8'(a), model(a));
    end
    @(negedge clk); apply(8'hFF, 8'h1E);
    @(negedge clk); apply(8'h00, 8'h80);
    @(negedge clk); apply(8'h01, 8'h61);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
